// File: rtl/pipe_ctrl.sv
// Pipeline hazard/trap controller: sequences stalls, flushes and PC redirects
// for the five-stage core, including trap entry/return and the post-reset boot.
module pipe_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_busy,
  input  logic        data_hazard,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        ex_ins_misalign,
  input  logic        ex_ins_illegal,
  input  logic        ex_ecall,
  input  logic        ex_ebreak,
  input  logic        ex_trap_return,
  input  logic [31:0] ex_pc,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        pipe_flush,
  output logic        pipe_stall,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        trap_enter,
  output logic [3:0]  trap_cause,
  output logic [31:0] trap_epc,
  output logic        trap_ret,
  output logic [1:0]  ctrl_state
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2,
    BOOT  = 2'd3
  } state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  logic ex_valid;
  logic trap_evt;
  logic ret_evt;

  // mtvec is word aligned on redirect; its mode bits are deliberately dropped
  logic unused_mtvec_bits;
  assign unused_mtvec_bits = &{1'b0, mtvec[1:0]};

  assign ex_valid = (ex_pc != 32'hffff_ffff);
  assign trap_evt = ex_valid & (ex_ins_misalign | ex_ins_illegal | ex_ecall | ex_ebreak);
  assign ret_evt  = ex_valid & ex_trap_return;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BOOT;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    pipe_flush  = 1'b0;
    pipe_stall  = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = 32'd0;
    trap_enter  = 1'b0;
    trap_cause  = 4'd0;
    trap_epc    = 32'd0;
    trap_ret    = 1'b0;

    case (state_reg)
      BOOT: begin
        pipe_flush  = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = RESET_PC;
        state_next  = DRAIN;
        cnt_next    = DRAIN_INIT;
      end

      DRAIN: begin
        pipe_flush = 1'b1;
        if (dmem_busy) begin
          pipe_stall = 1'b1;
        end else if (cnt_reg == 4'd0) begin
          state_next = RUN;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      // STALL with dmem_busy released behaves exactly like RUN in that cycle
      default: begin
        if (dmem_busy) begin
          pipe_stall = 1'b1;
          state_next = STALL;
        end else if (trap_evt) begin
          trap_enter  = 1'b1;
          pipe_flush  = 1'b1;
          pc_redirect = 1'b1;
          pc_target   = {mtvec[31:2], 2'b00};
          trap_epc    = ex_pc;
          if (ex_ins_misalign)     trap_cause = 4'd0;
          else if (ex_ins_illegal) trap_cause = 4'd2;
          else if (ex_ebreak)      trap_cause = 4'd3;
          else                     trap_cause = 4'd11;
          state_next  = DRAIN;
          cnt_next    = DRAIN_INIT;
        end else if (ret_evt) begin
          trap_ret    = 1'b1;
          pipe_flush  = 1'b1;
          pc_redirect = 1'b1;
          pc_target   = mepc;
          state_next  = DRAIN;
          cnt_next    = DRAIN_INIT;
        end else begin
          state_next = RUN;
          if (branch_taken) begin
            pipe_flush  = 1'b1;
            pc_redirect = 1'b1;
            pc_target   = branch_target;
          end
        end
      end
    endcase
  end

  assign ctrl_state = state_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: boot sequence, traps, stalls, returns,
// branches, cause priority and asynchronous reset recovery.
module tb_pipe_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmem_busy, data_hazard, branch_taken;
  logic [31:0] branch_target;
  logic        ex_ins_misalign, ex_ins_illegal, ex_ecall, ex_ebreak, ex_trap_return;
  logic [31:0] ex_pc, mtvec, mepc;
  logic        pipe_flush, pipe_stall, pc_redirect, trap_enter, trap_ret;
  logic [31:0] pc_target, trap_epc;
  logic [3:0]  trap_cause;
  logic [1:0]  ctrl_state;
  logic [4:0]  ctl;

  int checks = 0;
  int errors = 0;

  // {flush, stall, redirect, trap_enter, trap_ret}
  assign ctl = {pipe_flush, pipe_stall, pc_redirect, trap_enter, trap_ret};

  pipe_ctrl #(.RESET_PC(RST_PC), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .dmem_busy(dmem_busy), .data_hazard(data_hazard),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .ex_ins_misalign(ex_ins_misalign), .ex_ins_illegal(ex_ins_illegal),
    .ex_ecall(ex_ecall), .ex_ebreak(ex_ebreak), .ex_trap_return(ex_trap_return),
    .ex_pc(ex_pc), .mtvec(mtvec), .mepc(mepc),
    .pipe_flush(pipe_flush), .pipe_stall(pipe_stall), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .trap_enter(trap_enter), .trap_cause(trap_cause),
    .trap_epc(trap_epc), .trap_ret(trap_ret), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    dmem_busy = 0; data_hazard = 0; branch_taken = 0; branch_target = 0;
    ex_ins_misalign = 0; ex_ins_illegal = 0; ex_ecall = 0; ex_ebreak = 0;
    ex_trap_return = 0; ex_pc = 32'h0000_0000;
  endtask

  task automatic test_reset();
    rst_n = 0; clear_inputs(); mtvec = 32'h0000_0203; mepc = 32'h0000_0300;
    @(negedge clk); #1;
    checks++; if (ctrl_state !== 2'd3) begin errors++; $display("FAIL rst_state: got %0d want 3", ctrl_state); end
    checks++; if (ctl !== 5'b10100) begin errors++; $display("FAIL rst_ctl: got %b want 10100", ctl); end
    checks++; if (pc_target !== RST_PC) begin errors++; $display("FAIL rst_target: got %h want %h", pc_target, RST_PC); end
    checks++; if ({trap_epc, trap_cause} !== 36'd0) begin errors++; $display("FAIL rst_epc_cause: got %h/%0d want 0/0", trap_epc, trap_cause); end
    @(negedge clk); rst_n = 1; #1;
    checks++; if (ctrl_state !== 2'd3 || ctl !== 5'b10100) begin errors++; $display("FAIL boot_cycle: got state %0d ctl %b want 3 10100", ctrl_state, ctl); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++; if (ctrl_state !== 2'd2 || ctl !== 5'b10000 || pc_target !== 32'd0) begin
        errors++; $display("FAIL boot_drain%0d: got state %0d ctl %b tgt %h want 2 10000 0", i, ctrl_state, ctl, pc_target); end
    end
    @(negedge clk); #1;
    checks++; if (ctrl_state !== 2'd0 || ctl !== 5'b00000) begin errors++; $display("FAIL boot_run: got state %0d ctl %b want 0 00000", ctrl_state, ctl); end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_ecall();
    ex_ecall = 1; ex_pc = 32'h100; #1;
    checks++; if (ctl !== 5'b10110) begin errors++; $display("FAIL ecall_ctl: got %b want 10110", ctl); end
    checks++; if (trap_cause !== 4'd11) begin errors++; $display("FAIL ecall_cause: got %0d want 11", trap_cause); end
    checks++; if (trap_epc !== 32'h100) begin errors++; $display("FAIL ecall_epc: got %h want 100", trap_epc); end
    checks++; if (pc_target !== 32'h200) begin errors++; $display("FAIL ecall_target: got %h want 200", pc_target); end
    @(negedge clk); ex_pc = 32'h104; ex_trap_return = 1; branch_taken = 1; branch_target = 32'h40; #1;
    checks++; if (ctrl_state !== 2'd2 || ctl !== 5'b10000) begin errors++; $display("FAIL ecall_drain0: got state %0d ctl %b want 2 10000", ctrl_state, ctl); end
    checks++; if ({pc_target, trap_epc, trap_cause} !== 68'd0) begin errors++; $display("FAIL ecall_drain_zero: got %h %h %0d want 0 0 0", pc_target, trap_epc, trap_cause); end
    @(negedge clk); #1;
    checks++; if (ctrl_state !== 2'd2 || ctl !== 5'b10000) begin errors++; $display("FAIL ecall_drain1: got state %0d ctl %b want 2 10000", ctrl_state, ctl); end
    @(negedge clk); clear_inputs(); #1;
    checks++; if (ctrl_state !== 2'd0 || ctl !== 5'b00000) begin errors++; $display("FAIL ecall_run: got state %0d ctl %b want 0 00000", ctrl_state, ctl); end
    $display("test_ecall done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_stall_trap();
    dmem_busy = 1; ex_ins_illegal = 1; ex_pc = 32'h200; #1;
    checks++; if (ctrl_state !== 2'd0 || ctl !== 5'b01000) begin errors++; $display("FAIL stall_c0: got state %0d ctl %b want 0 01000", ctrl_state, ctl); end
    for (int i = 1; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (ctrl_state !== 2'd1 || ctl !== 5'b01000) begin errors++; $display("FAIL stall_c%0d: got state %0d ctl %b want 1 01000", i, ctrl_state, ctl); end
    end
    @(negedge clk); dmem_busy = 0; #1;
    checks++; if (ctrl_state !== 2'd1 || ctl !== 5'b10110) begin errors++; $display("FAIL stall_release: got state %0d ctl %b want 1 10110", ctrl_state, ctl); end
    checks++; if (trap_cause !== 4'd2 || trap_epc !== 32'h200) begin errors++; $display("FAIL stall_cause: got %0d/%h want 2/200", trap_cause, trap_epc); end
    // busy in the first drain cycle must freeze the counter for one extra cycle
    @(negedge clk); clear_inputs(); dmem_busy = 1; #1;
    checks++; if (ctrl_state !== 2'd2 || ctl !== 5'b11000) begin errors++; $display("FAIL drain_busy: got state %0d ctl %b want 2 11000", ctrl_state, ctl); end
    @(negedge clk); dmem_busy = 0; #1;
    checks++; if (ctrl_state !== 2'd2) begin errors++; $display("FAIL drain_frozen: got state %0d want 2", ctrl_state); end
    @(negedge clk); #1;
    checks++; if (ctrl_state !== 2'd2) begin errors++; $display("FAIL drain_last: got state %0d want 2", ctrl_state); end
    @(negedge clk); #1;
    checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL drain_exit: got state %0d want 0", ctrl_state); end
    $display("test_stall_trap done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_branch_ret();
    branch_taken = 1; branch_target = 32'h40; ex_trap_return = 1; ex_pc = 32'h50; #1;
    checks++; if (ctl !== 5'b10101 || pc_target !== 32'h300) begin errors++; $display("FAIL ret_pri: got ctl %b tgt %h want 10101 300", ctl, pc_target); end
    @(negedge clk); clear_inputs(); #1;
    checks++; if (ctrl_state !== 2'd2) begin errors++; $display("FAIL ret_drain: got state %0d want 2", ctrl_state); end
    @(negedge clk); @(negedge clk); #1;
    checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL ret_run: got state %0d want 0", ctrl_state); end
    branch_taken = 1; branch_target = 32'h40; data_hazard = 1; ex_pc = 32'h60; #1;
    checks++; if (ctl !== 5'b10100 || pc_target !== 32'h40) begin errors++; $display("FAIL branch: got ctl %b tgt %h want 10100 40", ctl, pc_target); end
    @(negedge clk); clear_inputs(); #1;
    checks++; if (ctrl_state !== 2'd0 || ctl !== 5'b00000) begin errors++; $display("FAIL branch_after: got state %0d ctl %b want 0 00000", ctrl_state, ctl); end
    ex_pc = 32'hffff_ffff; ex_ecall = 1; ex_trap_return = 1; #1;
    checks++; if (ctl !== 5'b00000 || {pc_target, trap_epc, trap_cause} !== 68'd0) begin
      errors++; $display("FAIL bubble: got ctl %b tgt %h epc %h cause %0d want all 0", ctl, pc_target, trap_epc, trap_cause); end
    clear_inputs(); data_hazard = 1; #1;
    checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL hazard: got ctl %b want 00000", ctl); end
    @(negedge clk); clear_inputs(); #1;
    checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL hazard_state: got %0d want 0", ctrl_state); end
    $display("test_branch_ret done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_cause_reset();
    ex_ins_misalign = 1; ex_ebreak = 1; ex_ecall = 1; ex_pc = 32'h80; #1;
    checks++; if (trap_cause !== 4'd0 || ctl !== 5'b10110) begin errors++; $display("FAIL cause_misalign: got %0d ctl %b want 0 10110", trap_cause, ctl); end
    ex_ins_misalign = 0; #1;
    checks++; if (trap_cause !== 4'd3) begin errors++; $display("FAIL cause_ebreak: got %0d want 3", trap_cause); end
    ex_ins_illegal = 1; #1;
    checks++; if (trap_cause !== 4'd2) begin errors++; $display("FAIL cause_illegal: got %0d want 2", trap_cause); end
    @(negedge clk); clear_inputs(); #1;
    checks++; if (ctrl_state !== 2'd2) begin errors++; $display("FAIL cause_drain: got %0d want 2", ctrl_state); end
    ex_ecall = 1; ex_pc = 32'h90; rst_n = 0; #1;
    checks++; if (ctrl_state !== 2'd3 || ctl !== 5'b10100 || pc_target !== RST_PC) begin
      errors++; $display("FAIL rst_in_drain: got state %0d ctl %b tgt %h want 3 10100 %h", ctrl_state, ctl, pc_target, RST_PC); end
    @(negedge clk); rst_n = 1; clear_inputs(); #1;
    checks++; if (ctrl_state !== 2'd3 || ctl !== 5'b10100) begin errors++; $display("FAIL restart_boot: got state %0d ctl %b want 3 10100", ctrl_state, ctl); end
    @(negedge clk); @(negedge clk); #1;
    checks++; if (ctrl_state !== 2'd2) begin errors++; $display("FAIL restart_drain: got %0d want 2", ctrl_state); end
    @(negedge clk); #1;
    checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL restart_run: got %0d want 0", ctrl_state); end
    dmem_busy = 1; ex_ins_illegal = 1; ex_pc = 32'ha0;
    @(negedge clk); #1;
    checks++; if (ctrl_state !== 2'd1) begin errors++; $display("FAIL stall_pre_rst: got %0d want 1", ctrl_state); end
    rst_n = 0; #1;
    checks++; if (ctrl_state !== 2'd3 || ctl !== 5'b10100) begin errors++; $display("FAIL rst_in_stall: got state %0d ctl %b want 3 10100", ctrl_state, ctl); end
    @(negedge clk); rst_n = 1; clear_inputs();
    $display("test_cause_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_stall_trap();
    test_branch_ret();
    test_cause_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
